// File: rtl/pio_clkdiv_bank.sv
// pio_clkdiv_bank: bank of independent fractional clock dividers.
//
// Each channel counts down from its effective integer divisor. A one-cycle
// penable tick marks every period boundary. pclk is an approximately 50%
// duty divided clock taken from the counter phase.
//
// Build option: define PIO_CLKDIV_FRAC_EN to enable fractional division.
// In that build a fractional accumulator adds one extra cycle to a period
// whenever it carries. Without it the fraction bits of div are ignored and
// the divider is integer-only. The port list is the same in both builds.
//
// An integer field of 0 selects 2^INT_W. This is why the counter and the
// latched period are one bit wider than the integer field.

module pio_clkdiv_bank #(
    parameter int NUM_CH = 4,
    parameter int INT_W  = 16,
    parameter int FRAC_W = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CH*(INT_W+FRAC_W)-1:0]  div,
    input  logic [NUM_CH-1:0]                 en,
    input  logic [NUM_CH-1:0]                 restart,
    output logic [NUM_CH-1:0]                 penable,
    output logic [NUM_CH-1:0]                 pclk
);

    localparam int DIV_W = INT_W + FRAC_W;

    genvar n;
    generate
        for (n = 0; n < NUM_CH; n++) begin : g_ch
            logic [INT_W-1:0]  int_field;
            logic [FRAC_W-1:0] frac_field;
            logic [INT_W:0]    int_eff;
            logic [INT_W:0]    reload_val;
            logic [INT_W:0]    cnt;
            logic [INT_W:0]    period;
            logic              carry;
            logic              cnt_zero;

            assign int_field  = div[n*DIV_W+FRAC_W +: INT_W];
            assign frac_field = div[n*DIV_W +: FRAC_W];
            assign int_eff    = (int_field == '0) ? {1'b1, {INT_W{1'b0}}}
                                                  : {1'b0, int_field};
            assign cnt_zero   = (cnt == '0);

`ifdef PIO_CLKDIV_FRAC_EN
            logic [FRAC_W-1:0] frac_acc;
            logic [FRAC_W:0]   frac_sum;

            assign frac_sum = {1'b0, frac_acc} + {1'b0, frac_field};
            assign carry    = frac_sum[FRAC_W];

            // Fractional accumulator: advances once per reload, cleared on reset/restart.
            always_ff @(posedge clk) begin
                if (reset || restart[n]) begin
                    frac_acc <= '0;
                end else if (en[n] && cnt_zero) begin
                    frac_acc <= frac_sum[FRAC_W-1:0];
                end
            end
`else
            logic unused_frac;

            assign unused_frac = ^frac_field;
            assign carry       = 1'b0;
`endif

            // A carry out of the fraction stretches the next period by one cycle.
            assign reload_val = int_eff - {{INT_W{1'b0}}, 1'b1}
                                        + {{INT_W{1'b0}}, carry};

            // Period counter: reset > restart > enabled count/reload; frozen when disabled.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt    <= '0;
                    period <= {{INT_W{1'b0}}, 1'b1};
                end else if (restart[n]) begin
                    cnt <= '0;
                end else if (en[n]) begin
                    if (cnt_zero) begin
                        cnt    <= reload_val;
                        period <= int_eff;
                    end else begin
                        cnt <= cnt - {{INT_W{1'b0}}, 1'b1};
                    end
                end
            end

            assign penable[n] = en[n] & cnt_zero & ~reset & ~restart[n];
            assign pclk[n]    = (cnt >= (period >> 1));
        end
    endgenerate

endmodule

// File: tb/tb_pio_clkdiv_bank.sv
// Testbench for pio_clkdiv_bank (NUM_CH=4, INT_W=16, FRAC_W=8).
// Expectations are queued when a cycle's inputs are driven. They are popped
// and compared on the falling edge of that same cycle.
// The fractional scenario picks its expected tick map according to whether
// PIO_CLKDIV_FRAC_EN is defined.

module tb_pio_clkdiv_bank;

    localparam int NUM_CH = 4;
    localparam int INT_W  = 16;
    localparam int FRAC_W = 8;
    localparam int DW     = INT_W + FRAC_W;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NUM_CH*DW-1:0]   div = '0;
    logic [NUM_CH-1:0]      en = '0;
    logic [NUM_CH-1:0]      restart = '0;
    logic [NUM_CH-1:0]      penable;
    logic [NUM_CH-1:0]      pclk;

    always #5 clk = ~clk;

    pio_clkdiv_bank #(
        .NUM_CH (NUM_CH),
        .INT_W  (INT_W),
        .FRAC_W (FRAC_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .div     (div),
        .en      (en),
        .restart (restart),
        .penable (penable),
        .pclk    (pclk)
    );

    typedef struct {
        logic [3:0] xp;
        logic [3:0] pm;
        logic [3:0] xc;
        logic [3:0] cm;
        string      tag;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [3:0] en;
        logic [3:0] rs;
        logic [3:0] xp;
        logic [3:0] xc;
        logic [3:0] cm;
    } vec_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            checks++;
            if ((((penable ^ cur.xp) & cur.pm) != 4'h0) ||
                (((pclk ^ cur.xc) & cur.cm) != 4'h0)) begin
                errors++;
                $display("FAIL %s: penable=%b expected %b (mask %b) pclk=%b expected %b (mask %b)",
                         cur.tag, penable, cur.xp, cur.pm, pclk, cur.xc, cur.cm);
            end
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: stimulus did not complete in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic set_div(input int ch, input logic [INT_W-1:0] iv, input logic [FRAC_W-1:0] fv);
        div[ch*DW +: DW] = {iv, fv};
    endtask

    task automatic drive(input logic r, input logic [3:0] e, input logic [3:0] rs,
                         input logic [3:0] xp, input logic [3:0] pm,
                         input logic [3:0] xc, input logic [3:0] cm, input string tag);
        @(posedge clk);
        #1;
        reset   = r;
        en      = e;
        restart = rs;
        if (pm != 4'h0 || cm != 4'h0) begin
            sb.push_back('{xp: xp, pm: pm, xc: xc, cm: cm, tag: tag});
        end
    endtask

    vec_t        tbl[19];
    logic [15:0] tick_map;
    logic [3:0]  xp_v;
    logic [3:0]  xc_v;

    initial begin
        // Channel divisors for the table: 1.0, 2.0, 4.0, 1.0
        set_div(0, 16'd1, 8'h00);
        set_div(1, 16'd2, 8'h00);
        set_div(2, 16'd4, 8'h00);
        set_div(3, 16'd1, 8'h00);

        @(negedge clk);
        checks++;
        if (penable !== 4'h0 || pclk !== 4'hF) begin
            errors++;
            $display("FAIL reset_state: penable=%b expected 0000 pclk=%b expected 1111",
                     penable, pclk);
        end

        //            rst   en     rs     xp     xc     cm
        tbl[0]  = '{1'b1, 4'hF, 4'h5, 4'h0, 4'hF, 4'h0};
        tbl[1]  = '{1'b1, 4'hF, 4'hA, 4'h0, 4'hF, 4'hF};
        tbl[2]  = '{1'b0, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF};
        tbl[3]  = '{1'b0, 4'hF, 4'h0, 4'h9, 4'hF, 4'hF};
        tbl[4]  = '{1'b0, 4'hF, 4'h0, 4'hB, 4'hD, 4'hF};
        tbl[5]  = '{1'b0, 4'hF, 4'h0, 4'h9, 4'hB, 4'hF};
        tbl[6]  = '{1'b0, 4'hF, 4'h0, 4'hF, 4'h9, 4'hF};
        tbl[7]  = '{1'b0, 4'hF, 4'h0, 4'h9, 4'hF, 4'hF};
        tbl[8]  = '{1'b0, 4'hF, 4'h0, 4'hB, 4'hD, 4'hF};
        tbl[9]  = '{1'b0, 4'hF, 4'h0, 4'h9, 4'hB, 4'hF};
        tbl[10] = '{1'b0, 4'hF, 4'h0, 4'hF, 4'h9, 4'hF};
        tbl[11] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF};
        tbl[12] = '{1'b0, 4'hF, 4'h0, 4'h9, 4'hF, 4'hF};
        tbl[13] = '{1'b0, 4'hF, 4'h4, 4'hB, 4'hD, 4'hF};
        tbl[14] = '{1'b0, 4'hF, 4'h0, 4'hD, 4'hB, 4'hF};
        tbl[15] = '{1'b1, 4'hF, 4'h0, 4'h0, 4'hD, 4'hF};
        tbl[16] = '{1'b1, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF};
        tbl[17] = '{1'b0, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF};
        tbl[18] = '{1'b0, 4'hF, 4'h0, 4'h9, 4'hF, 4'hF};

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].rs, tbl[i].xp, 4'hF,
                  tbl[i].xc, tbl[i].cm, $sformatf("vec%0d", i));
        end

        // Divisor 2.5 on channel 0 from reset; other channels disabled
`ifdef PIO_CLKDIV_FRAC_EN
        tick_map = 16'h94A5;
`else
        tick_map = 16'h5555;
`endif
        set_div(0, 16'd2, 8'h80);
        drive(1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, "frac_reset");
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 4'h1, 4'h0, {3'b000, tick_map[i]}, 4'hF, 4'h0, 4'h0,
                  $sformatf("frac_c%0d", i));
        end

        // Divisor 4.0, enable dropped for 3 cycles while pclk is low
        set_div(0, 16'd4, 8'h00);
        drive(1'b0, 4'h1, 4'h1, 4'h0, 4'hF, 4'h0, 4'h0, "gate_restart");
        drive(1'b0, 4'h1, 4'h0, 4'h1, 4'hF, 4'h0, 4'h1, "gate_tick0");
        drive(1'b0, 4'h1, 4'h0, 4'h0, 4'hF, 4'h1, 4'h1, "gate_c2");
        drive(1'b0, 4'h1, 4'h0, 4'h0, 4'hF, 4'h1, 4'h1, "gate_c3");
        drive(1'b0, 4'h1, 4'h0, 4'h0, 4'hF, 4'h0, 4'h1, "gate_c4");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h1, $sformatf("gate_hold%0d", i));
        end
        drive(1'b0, 4'h1, 4'h0, 4'h1, 4'hF, 4'h0, 4'h1, "gate_tick_late");
        drive(1'b0, 4'h1, 4'h0, 4'h0, 4'hF, 4'h1, 4'h1, "gate_after");

        // Channels 0 and 1 at 3.0, first misaligned, then restarted together
        set_div(0, 16'd3, 8'h00);
        set_div(1, 16'd3, 8'h00);
        drive(1'b0, 4'h3, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, "phase_pre0");
        drive(1'b0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "phase_pre1");
        drive(1'b0, 4'h3, 4'h3, 4'h0, 4'hF, 4'h0, 4'h0, "phase_restart");
        for (int i = 1; i <= 8; i++) begin
            xp_v = (i % 3 == 1) ? 4'h3 : 4'h0;
            xc_v = (i % 3 == 1) ? 4'h0 : 4'h3;
            drive(1'b0, 4'h3, 4'h0, xp_v, 4'hF, xc_v, (i == 1) ? 4'h0 : 4'h3,
                  $sformatf("phase_k%0d", i));
        end

        // Divisor 8.0 changed to 2.0 mid-period
        set_div(0, 16'd8, 8'h00);
        drive(1'b0, 4'h1, 4'h1, 4'h0, 4'hF, 4'h0, 4'h0, "chg_restart");
        for (int i = 1; i <= 14; i++) begin
            xp_v = (i == 1 || i == 9 || i == 11 || i == 13) ? 4'h1 : 4'h0;
            if (i <= 5)           xc_v = 4'h1;
            else if (i <= 9)      xc_v = 4'h0;
            else if (i % 2 == 0)  xc_v = 4'h1;
            else                  xc_v = 4'h0;
            drive(1'b0, 4'h1, 4'h0, xp_v, 4'hF, xc_v, (i >= 2) ? 4'h1 : 4'h0,
                  $sformatf("chg_k%0d", i));
            if (i == 3) begin
                set_div(0, 16'd2, 8'h00);
            end
        end

        // Integer field 0 on channel 3: 65536-cycle spacing
        set_div(3, 16'd0, 8'h00);
        drive(1'b0, 4'h8, 4'h8, 4'h0, 4'hF, 4'h0, 4'h0, "zero_restart");
        drive(1'b0, 4'h8, 4'h0, 4'h8, 4'hF, 4'h0, 4'h0, "zero_first");
        for (int i = 2; i <= 65538; i++) begin
            drive(1'b0, 4'h8, 4'h0, (i == 65537) ? 4'h8 : 4'h0, 4'h8, 4'h0, 4'h0,
                  (i == 65537) ? "zero_second_tick" : "zero_gap");
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
